// File: rtl/if_fetch_buffer.sv
// Instruction-fetch buffer and IF/ID pipeline register: issues in-order imem requests at the PC,
// queues returned instructions with their PC+4, and presents the oldest to ID with stall and flush.
module if_fetch_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter logic [31:0] NOP   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic [31:0] pc_add,
    output logic        pc_write_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    input  logic        id_stall,
    input  logic        flush,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic        id_valid
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t FULL = cnt_t'(DEPTH);

    logic [31:0]      r_pc4   [DEPTH];
    logic [31:0]      r_instr [DEPTH];
    logic [DEPTH-1:0] r_filled;

    ptr_t r_alloc_ptr;
    ptr_t r_fill_ptr;
    ptr_t r_head_ptr;
    cnt_t r_count;
    cnt_t r_pending;
    cnt_t r_drop_cnt;

    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc4;
    logic        r_id_valid;

    logic w_req;
    logic w_fill;
    logic w_head_ready;
    logic w_pop;
    cnt_t w_inflight;
    cnt_t w_flush_drop;

    // r_pending counts allocated-but-unfilled entries, so a legal response always has a target.
    assign w_req        = !rst && !flush && (r_count < FULL) && (r_drop_cnt == '0);
    assign w_fill       = !flush && imem_rvalid && (r_drop_cnt == '0) && (r_pending != '0);
    assign w_head_ready = (r_count != '0) && r_filled[r_head_ptr];
    assign w_pop        = !id_stall && w_head_ready;

    // A response arriving in the flush cycle is consumed right there instead of being counted.
    assign w_inflight   = r_drop_cnt + r_pending;
    assign w_flush_drop = (imem_rvalid && (w_inflight != '0)) ? w_inflight - cnt_t'(1) : w_inflight;

    assign imem_req   = w_req;
    assign imem_addr  = pc;
    assign pc_write_n = rst || !(w_req || flush);

    assign id_instr = r_id_instr;
    assign id_pc4   = r_id_pc4;
    assign id_valid = r_id_valid;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filled    <= '0;
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_count     <= '0;
            r_pending   <= '0;
            r_drop_cnt  <= '0;
            r_id_instr  <= NOP;
            r_id_pc4    <= '0;
            r_id_valid  <= 1'b0;
        end else if (flush) begin
            r_filled    <= '0;
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_count     <= '0;
            r_pending   <= '0;
            r_drop_cnt  <= w_flush_drop;
            r_id_instr  <= NOP;
            r_id_pc4    <= '0;
            r_id_valid  <= 1'b0;
        end else begin
            if (w_req) begin
                r_filled[r_alloc_ptr] <= 1'b0;
                r_alloc_ptr           <= r_alloc_ptr + ptr_t'(1);
            end
            if (w_fill) begin
                r_filled[r_fill_ptr] <= 1'b1;
                r_fill_ptr           <= r_fill_ptr + ptr_t'(1);
            end
            if (imem_rvalid && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - cnt_t'(1);
            end
            if (w_pop) begin
                r_head_ptr <= r_head_ptr + ptr_t'(1);
            end
            r_count   <= r_count + cnt_t'(w_req) - cnt_t'(w_pop);
            r_pending <= r_pending + cnt_t'(w_req) - cnt_t'(w_fill);

            if (!id_stall) begin
                if (w_head_ready) begin
                    r_id_instr <= r_instr[r_head_ptr];
                    r_id_pc4   <= r_pc4[r_head_ptr];
                    r_id_valid <= 1'b1;
                end else begin
                    r_id_instr <= NOP;
                    r_id_pc4   <= '0;
                    r_id_valid <= 1'b0;
                end
            end
        end
    end

    // NOTE: payload storage has no reset; entries are only read once their filled flag is set.
    always_ff @(posedge clk) begin
        if (w_req) begin
            r_pc4[r_alloc_ptr] <= pc_add;
        end
        if (w_fill) begin
            r_instr[r_fill_ptr] <= imem_rdata;
        end
    end

endmodule

// File: doc/if_fetch_buffer.md
# if_fetch_buffer

Instruction-fetch buffer and IF/ID pipeline register, directly downstream of the program counter. The block issues instruction-memory requests at the current PC and tells the PC when to advance through an active-low write enable. Returned instructions and their PC+4 values are queued in a small FIFO, and the oldest is presented to the ID stage through the IF/ID register. The block decouples variable-latency instruction memory from hazard stalls and implements branch/jump flush.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2; also the maximum number of outstanding requests.
- NOP, 32'h0000_0000: instruction word loaded into the ID register when no valid instruction is available.

- clk  in  1  clock; all registers update on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- pc  in  32  current PC from the program counter.
- pc_add  in  32  PC+4 from the program counter.
- pc_write_n  out  1  PC write enable, active-low; drives the PC's PCWrite input.
- imem_req  out  1  request strobe; always accepted in the same cycle.
- imem_addr  out  32  request address; equals pc.
- imem_rdata  in  32  returned instruction.
- imem_rvalid  in  1  response strobe.
  - Exactly one response per request, in request order.
  - Latency ≥1 cycle.
- id_stall  in  1  hazard unit requests that the IF/ID register hold.
- flush  in  1  branch/jump taken; discard all fetched and in-flight instructions.
- id_instr  out  32  IF/ID instruction.
- id_pc4  out  32  IF/ID PC+4.
- id_valid  out  1  id_instr is a real instruction.

## Operation
- FIFO entries hold {pc4, instr, filled}. State pointers:
  - alloc_ptr: next entry to allocate.
  - fill_ptr: oldest entry not yet filled.
  - head_ptr: oldest allocated entry.
  - count: number of allocated entries, 0..DEPTH.
- drop_cnt: number of in-flight responses still to be discarded after a flush, 0..DEPTH.
- Request condition (combinational): imem_req = !rst & !flush & (count < DEPTH) & (drop_cnt == 0).
  - imem_addr = pc.
  - pc_write_n = !(imem_req | flush), so the PC advances exactly on an accepted request or on a flush redirect.
- On a request, the entry at alloc_ptr gets pc4 = pc_add and filled = 0; alloc_ptr and count increment.
- On imem_rvalid:
  - drop_cnt > 0: decrement drop_cnt and ignore the data.
  - Otherwise, if an unfilled allocated entry exists: write instr at fill_ptr, set filled = 1, increment fill_ptr.
  - Otherwise the strobe is a protocol violation and is ignored.
- IF/ID register when id_stall = 0:
  - Head entry filled: load id_instr/id_pc4 from the head, id_valid = 1, pop (head_ptr++, count--).
  - Head entry not filled: load id_instr = NOP, id_pc4 = 0, id_valid = 0.
- IF/ID register when id_stall = 1: hold all ID outputs; no pop.
- Allocate and pop may occur in the same cycle; count changes by net 0. A pop does not free space for a request in the same cycle; count is the registered value.
- Flush, which has priority over id_stall, over requests and over rvalid fill:
  - FIFO cleared: pointers and count = 0, all filled = 0.
  - ID register = NOP / 0 / valid 0.
  - drop_cnt = number of allocated-but-unfilled entries, minus 1 if imem_rvalid is high in the flush cycle (that response is discarded directly).
- No data bypass from imem_rdata to the ID register.

## Timing
- Reset values, and while rst is asserted:
  - id_instr = NOP, id_pc4 = 0, id_valid = 0.
  - count = 0, drop_cnt = 0, all pointers 0.
  - imem_req = 0, pc_write_n = 1.
- Asynchronous reset mid-operation discards everything. Responses arriving after reset release for pre-reset requests are a system error; the memory is reset together with this block.
- Request in cycle t with response in cycle t+L: the entry is filled at the end of t+L. If id_stall = 0, the ID register loads at the end of t+L+1, so id_valid = 1 from cycle t+L+2.
- Throughput with L = 1: DEPTH = 4 sustains 1 instruction per cycle; DEPTH = 2 sustains 2 per 3 cycles.
- Flush in cycle f:
  - pc_write_n = 0 in f, so the PC loads the branch/jump target at the end of f.
  - imem_req = 0 in f.
  - The first request at the new target is in f+1 if drop_cnt = 0, otherwise in the cycle after the last dropped response.
- FIFO full (count = DEPTH): imem_req = 0 and pc_write_n = 1, so the PC holds.
- Pointers wrap modulo DEPTH.

## Test plan
- Reset, then L = 1, id_stall = 0, pc = 0x0, 0x4, 0x8, ...
  - imem_addr sequence is 0x0, 0x4, 0x8, 0xC.
  - id_valid first rises 3 cycles after the first request.
  - id_pc4 = 0x4, 0x8, 0xC in order.
  - After fill, there is one instruction per cycle with DEPTH = 4.
- id_stall held high for 10 cycles, L = 1:
  - count reaches 4, then imem_req = 0 and pc_write_n = 1.
  - ID outputs are constant throughout.
  - After release, 4 instructions emerge in order with no loss or duplication.
- L = 3 with 3 requests outstanding, flush pulsed one cycle:
  - pc_write_n = 0 and imem_req = 0 in the flush cycle.
  - id_valid = 0 the next cycle.
  - The 3 late responses (data 0xDEAD0001..3) never reach id_instr.
  - The first new request is issued the cycle after the third response.
- flush and id_stall asserted together: flush wins; id_valid = 0 and the FIFO is empty the next cycle.
- Flush in the same cycle as an imem_rvalid with 2 outstanding: drop_cnt = 1 and exactly one further response is discarded.
- rst asserted asynchronously mid-stream with count = 3:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, fetch resumes at pc = 0x0 with id_pc4 = 0x4.
